// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizing constants for the issue-stage register scoreboard
package reg_scoreboard_pkg;

    // Default architectural sizing; the top module exposes these as overridable parameters.
    localparam int NUM_REGS_DEF        = 32;
    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int CNT_W_DEF           = 32;

    // Register address width and its all-zero value (x0 / "no register").
    localparam int                   ADDR_BITS      = $clog2(NUM_REGS_DEF);
    localparam logic [ADDR_BITS-1:0] ADDR_BITS_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue and writeback handshake bundle between ID/WB and the scoreboard
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int AW = ADDR_BITS
) ();

    // Decoded instruction sitting in ID
    logic          id_valid;
    logic [AW-1:0] id_rd;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rs3;
    logic          id_long;
    logic          ex_ready;

    // Issue decision returned by the scoreboard
    logic          id_ready;
    logic          issue_fire;

    // Long-latency writeback
    logic          wb_valid;
    logic [AW-1:0] wb_rd;

    modport master (
        output id_valid, id_rd, id_rs1, id_rs2, id_rs3, id_long, ex_ready,
        output wb_valid, wb_rd,
        input  id_ready, issue_fire
    );

    modport slave (
        input  id_valid, id_rd, id_rs1, id_rs2, id_rs3, id_long, ex_ready,
        input  wb_valid, wb_rd,
        output id_ready, issue_fire
    );

endinterface

// File: rtl/sb_hazard_check.sv
// rtl/sb_hazard_check.sv - combinational RAW/WAW decode against a pending-register bitmap
module sb_hazard_check #(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] eff_pending,
    input  logic [AW-1:0]       rd,
    input  logic [AW-1:0]       rs1,
    input  logic [AW-1:0]       rs2,
    input  logic [AW-1:0]       rs3,
    output logic                raw,
    output logic                waw
);

    // Address 0 means "field unused", so it never produces a hazard even if bit 0 were set.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        if ((rs1 != '0) && eff_pending[rs1]) raw = 1'b1;
        if ((rs2 != '0) && eff_pending[rs2]) raw = 1'b1;
        if ((rs3 != '0) && eff_pending[rs3]) raw = 1'b1;
        if ((rd  != '0) && eff_pending[rd])  waw = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-stage scoreboard tracking long-latency destinations and stalling on hazards
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    reg_scoreboard_if.slave                        sb,
    output logic [NUM_REGS-1:0]                    pending_mask,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   wb_err,
    output logic [CNT_W-1:0]                       stall_cycles
);

    localparam int                AW      = $clog2(NUM_REGS);
    localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]  MAX_CNT = OUT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                wb_err_q, wb_err_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic [NUM_REGS-1:0] wb_onehot;
    logic [NUM_REGS-1:0] set_onehot;
    logic [NUM_REGS-1:0] eff_pending;
    logic                wb_nz;
    logic                wb_clear;
    logic                set_pend;
    logic                raw;
    logic                waw;
    logic                full;
    logic                ready_c;

    // Writeback bypass: a register being written back this cycle no longer blocks issue.
    always_comb begin
        wb_onehot = '0;
        wb_nz     = sb.wb_valid && (sb.wb_rd != ADDR_BITS_ZERO);
        if (wb_nz) wb_onehot[sb.wb_rd] = 1'b1;
        wb_clear    = wb_nz && pending_q[sb.wb_rd];
        eff_pending = pending_q & ~wb_onehot;
    end

    sb_hazard_check #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_hazard (
        .eff_pending (eff_pending),
        .rd          (sb.id_rd),
        .rs1         (sb.id_rs1),
        .rs2         (sb.id_rs2),
        .rs3         (sb.id_rs3),
        .raw         (raw),
        .waw         (waw)
    );

    // Issue decision; a writeback freeing a slot this cycle lets a new long op take it.
    always_comb begin
        full    = sb.id_long && (sb.id_rd != ADDR_BITS_ZERO) &&
                  ((outstanding_q - OUT_W'(wb_clear)) == MAX_CNT);
        ready_c = sb.ex_ready && !raw && !waw && !full;
    end

    assign sb.id_ready   = ready_c;
    assign sb.issue_fire = sb.id_valid && ready_c;

    // Next-state: set of a newly issued long op wins over a same-cycle clear of that register.
    always_comb begin
        set_onehot = '0;
        set_pend   = sb.issue_fire && sb.id_long && (sb.id_rd != ADDR_BITS_ZERO);
        if (set_pend) set_onehot[sb.id_rd] = 1'b1;
        pending_d    = eff_pending | set_onehot;
        pending_d[0] = 1'b0;
        outstanding_d = outstanding_q + OUT_W'(set_pend) - OUT_W'(wb_clear);
        wb_err_d      = wb_nz && !pending_q[sb.wb_rd];
        stall_d       = stall_q;
        if (sb.id_valid && !ready_c && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end

    // State registers; reset drops all tracking immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            wb_err_q      <= 1'b0;
            stall_q       <= '0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            wb_err_q      <= wb_err_d;
            stall_q       <= stall_d;
        end
    end

    assign pending_mask = pending_q;
    assign outstanding  = outstanding_q;
    assign wb_err       = wb_err_q;
    assign stall_cycles = stall_q;

endmodule
